// File: rtl/prod_accum.sv
// Block-sum accumulator for multiplier products: sums up to LEN beats (or
// until in_last), then holds the sum and beat count until they are accepted.
module prod_accum #(
  parameter int SIZE  = 8,
  parameter int LEN   = 4,
  parameter int GUARD = 4,
  localparam int PW   = 2*SIZE,
  localparam int AW   = 2*SIZE+GUARD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_sum,
  output logic [GUARD:0]   out_count
);

  typedef enum logic {ACC, OUT} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_acc;
  logic [GUARD:0]   r_cnt;
  logic [AW-1:0]    r_sum;
  logic [GUARD:0]   r_count;

  logic             w_accept;
  logic [AW-1:0]    w_acc_nxt;
  logic [GUARD:0]   w_cnt_nxt;
  logic             w_end;

  // Ready depends only on state and reset, never on in_valid.
  assign in_ready  = (r_state == ACC) && !rst;
  assign out_valid = (r_state == OUT);
  assign out_sum   = r_sum;
  assign out_count = r_count;

  assign w_accept  = in_valid && in_ready;
  assign w_acc_nxt = r_acc + {{GUARD{1'b0}}, in_prod};
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_end     = (w_cnt_nxt == (GUARD+1)'(LEN)) || in_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACC;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ACC: if (w_accept) begin
          if (w_end) begin
            r_sum   <= w_acc_nxt;
            r_count <= w_cnt_nxt;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= OUT;
          end else begin
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
          end
        end
        // No bypass: the next block starts the cycle after the handshake.
        OUT: if (out_ready) r_state <= ACC;
        default: r_state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Randomized + directed bench for prod_accum against a queue-based block model.
module tb_prod_accum;
  localparam int SIZE = 8, LEN = 4, GUARD = 4;
  localparam int PW = 2*SIZE, AW = 2*SIZE+GUARD;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_sum;
  logic [GUARD:0]   out_count;

  prod_accum #(.SIZE(SIZE), .LEN(LEN), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Model: beats of the open block, and the pending/last delivered result.
  longint m_blk[$];
  bit     m_hold;
  longint m_sum, m_cnt;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_blk.delete();
    m_hold = 0; m_sum = 0; m_cnt = 0;
  endtask

  // Check outputs of the current cycle, drive one cycle, advance the model.
  task automatic cyc(input bit v, input longint p, input bit l, input bit ordy, input bit r);
    chk("in_ready", in_ready, (!m_hold && !rst) ? 1 : 0);
    chk("out_valid", out_valid, m_hold ? 1 : 0);
    chk("out_sum", out_sum, m_sum);
    chk("out_count", out_count, m_cnt);
    in_valid = v; in_prod = PW'(p); in_last = l; out_ready = ordy; rst = r;
    @(posedge clk);
    if (r) model_reset();
    else if (m_hold) begin
      if (ordy) m_hold = 0;
    end else if (v) begin
      m_blk.push_back(p);
      if (m_blk.size() == LEN || l) begin
        longint s = 0;
        foreach (m_blk[i]) s += m_blk[i];
        m_sum  = s % (64'sd1 << AW);
        m_cnt  = m_blk.size();
        m_hold = 1;
        m_blk.delete();
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_prod = '0; in_last = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_sum", out_sum, 0);
    chk("rst_cnt", out_count, 0);
    chk("rst_ovld", out_valid, 0);
    chk("rst_irdy", in_ready, 0);
    cyc(0, 0, 0, 0, 0);

    // Full block
    cyc(1, 100, 0, 0, 0); cyc(1, 200, 0, 0, 0); cyc(1, 300, 0, 0, 0); cyc(1, 400, 0, 0, 0);
    chk("blk1_sum", out_sum, 1000);
    chk("blk1_cnt", out_count, 4);
    chk("blk1_vld", out_valid, 1);
    cyc(0, 0, 0, 1, 0);
    chk("blk1_irdy", in_ready, 1);

    // Max values
    repeat (4) cyc(1, 65025, 0, 0, 0);
    chk("max_sum", out_sum, 260100);
    cyc(0, 0, 0, 1, 0);

    // Early end then fresh block
    cyc(1, 7, 0, 0, 0); cyc(1, 9, 1, 0, 0);
    chk("early_sum", out_sum, 16);
    chk("early_cnt", out_count, 2);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0); cyc(1, 2, 0, 0, 0); cyc(1, 3, 0, 0, 0); cyc(1, 4, 1, 0, 0);
    chk("after_sum", out_sum, 10);
    chk("after_cnt", out_count, 4);

    // Backpressure: result held, offered beats not taken
    repeat (5) cyc(1, 5, 0, 0, 0);
    chk("bp_sum", out_sum, 10);
    chk("bp_irdy", in_ready, 0);
    cyc(1, 5, 0, 1, 0);
    chk("bp_rel_irdy", in_ready, 1);
    cyc(1, 5, 1, 0, 0);
    chk("bp_new_sum", out_sum, 5);
    chk("bp_new_cnt", out_count, 1);
    cyc(0, 0, 0, 1, 0);

    // Bubbles
    cyc(1, 3, 0, 0, 0); cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0); cyc(1, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 0); cyc(1, 5, 0, 0, 0); cyc(1, 6, 0, 0, 0);
    chk("bub_sum", out_sum, 18);
    chk("bub_cnt", out_count, 4);
    cyc(0, 0, 0, 1, 0);

    // Reset mid-block
    cyc(1, 50, 0, 0, 0); cyc(1, 60, 0, 0, 0);
    rst = 1;
    #1 chk("rst_mid_irdy", in_ready, 0);
    cyc(0, 0, 0, 0, 1);
    chk("rst_mid_sum", out_sum, 0);
    chk("rst_mid_vld", out_valid, 0);
    repeat (4) cyc(1, 1, 0, 0, 0);
    chk("rst_after_sum", out_sum, 4);
    chk("rst_after_cnt", out_count, 4);
    cyc(0, 0, 0, 1, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 65535), $urandom_range(0, 5) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
